// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between two requesting drivers. Whole transactions are
// granted round-robin, the arbiter owns the physical chip-selects, a guard gap
// with every CSN high separates owners, and a hold timeout forces a release.
module spi_bus_arbiter #(
    parameter int unsigned GUARD_CYC   = 8,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        En,
    input  logic [1:0]  Req,
    output logic [1:0]  Gnt,
    input  logic [1:0]  En_SPI_Req,
    input  logic [15:0] SBUF_Req,
    input  logic [1:0]  CSN_Req,
    output logic [7:0]  RBUF_Req,
    output logic [1:0]  Dat_Rdy_Req,
    output logic [1:0]  Busy_Req,
    output logic [1:0]  SPI_Rdy_Req,
    output logic        SPI_En,
    output logic [7:0]  SPI_SBUF,
    input  logic [7:0]  SPI_RBUF,
    input  logic        SPI_Dat_Rdy,
    input  logic        SPI_Busy,
    input  logic        SPI_Rdy,
    output logic [1:0]  CSN_Out,
    output logic        Timeout_Flg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  gnt_q;
    logic        last_q;
    logic [15:0] hold_q;
    logic [15:0] hold_d;
    logic [7:0]  guard_q;
    logic        tmo_q;

    logic        own_idx;
    logic        own_req;
    logic        hold_exp;
    logic        win_idx;

    // Owner lookup, winner selection and saturating hold-count next value
    always_comb begin
        own_idx  = gnt_q[1];
        own_req  = Req[own_idx];
        hold_exp = (hold_q >= (TIMEOUT_CYC - 16'd1));
        hold_d   = (hold_q == TIMEOUT_CYC) ? hold_q : (hold_q + 16'd1);
        case (Req)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            default: win_idx = ~last_q;   // tie goes to whoever was not granted last
        endcase
    end

    // Arbitration FSM: grant, hold until release/timeout, then enforce guard gap
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            hold_q  <= 16'd0;
            guard_q <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (En && SPI_Rdy && (Req != 2'b00)) begin
                        gnt_q   <= win_idx ? 2'b10 : 2'b01;
                        last_q  <= win_idx;
                        hold_q  <= 16'd0;
                        state_q <= OWN;
                    end
                end
                OWN: begin
                    hold_q <= hold_d;
                    // A byte in flight always completes before the bus is released
                    if (!SPI_Busy && (!own_req || hold_exp)) begin
                        gnt_q   <= 2'b00;
                        guard_q <= 8'd0;
                        tmo_q   <= own_req;   // only flag releases the owner did not ask for
                        state_q <= GUARD;
                    end
                end
                GUARD: begin
                    if (guard_q == 8'(GUARD_CYC - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        guard_q <= guard_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // Zero-latency steering between the owner and the shared SPI master
    always_comb begin
        SPI_En      = 1'b0;
        SPI_SBUF    = 8'h00;
        RBUF_Req    = 8'h00;
        Dat_Rdy_Req = 2'b00;
        Busy_Req    = 2'b11;
        SPI_Rdy_Req = 2'b00;
        CSN_Out     = 2'b11;
        if (gnt_q != 2'b00) begin
            SPI_En               = En_SPI_Req[own_idx];
            SPI_SBUF             = own_idx ? SBUF_Req[15:8] : SBUF_Req[7:0];
            RBUF_Req             = SPI_RBUF;
            Dat_Rdy_Req[own_idx] = SPI_Dat_Rdy;
            Busy_Req[own_idx]    = SPI_Busy;
            SPI_Rdy_Req[own_idx] = SPI_Rdy;
            CSN_Out[own_idx]     = CSN_Req[own_idx];
        end
    end

    assign Gnt         = gnt_q;
    assign Timeout_Flg = tmo_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant/steering, round-robin, guard gap,
// timeout, busy-extended release, enable gating and asynchronous reset.
module tb_spi_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        En;
    logic [1:0]  Req;
    logic [1:0]  Gnt;
    logic [1:0]  En_SPI_Req;
    logic [15:0] SBUF_Req;
    logic [1:0]  CSN_Req;
    logic [7:0]  RBUF_Req;
    logic [1:0]  Dat_Rdy_Req;
    logic [1:0]  Busy_Req;
    logic [1:0]  SPI_Rdy_Req;
    logic        SPI_En;
    logic [7:0]  SPI_SBUF;
    logic [7:0]  SPI_RBUF;
    logic        SPI_Dat_Rdy;
    logic        SPI_Busy;
    logic        SPI_Rdy;
    logic [1:0]  CSN_Out;
    logic        Timeout_Flg;

    int n_chk = 0;
    int n_err = 0;

    spi_bus_arbiter #(
        .GUARD_CYC  (8),
        .TIMEOUT_CYC(16'd100)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .En         (En),
        .Req        (Req),
        .Gnt        (Gnt),
        .En_SPI_Req (En_SPI_Req),
        .SBUF_Req   (SBUF_Req),
        .CSN_Req    (CSN_Req),
        .RBUF_Req   (RBUF_Req),
        .Dat_Rdy_Req(Dat_Rdy_Req),
        .Busy_Req   (Busy_Req),
        .SPI_Rdy_Req(SPI_Rdy_Req),
        .SPI_En     (SPI_En),
        .SPI_SBUF   (SPI_SBUF),
        .SPI_RBUF   (SPI_RBUF),
        .SPI_Dat_Rdy(SPI_Dat_Rdy),
        .SPI_Busy   (SPI_Busy),
        .SPI_Rdy    (SPI_Rdy),
        .CSN_Out    (CSN_Out),
        .Timeout_Flg(Timeout_Flg)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_reset();
        RSTn = 1'b0;
        #1;
        RSTn = 1'b1;
    endtask

    initial begin
        RSTn        = 1'b0;
        En          = 1'b1;
        Req         = 2'b00;
        En_SPI_Req  = 2'b00;
        SBUF_Req    = 16'h3C5A;
        CSN_Req     = 2'b11;
        SPI_RBUF    = 8'h00;
        SPI_Dat_Rdy = 1'b0;
        SPI_Busy    = 1'b0;
        SPI_Rdy     = 1'b1;
        #1;
        // reset values
        check_eq("rst_gnt",   Gnt, 2'b00);
        check_eq("rst_csn",   CSN_Out, 2'b11);
        check_eq("rst_en",    SPI_En, 1'b0);
        check_eq("rst_sbuf",  SPI_SBUF, 8'h00);
        check_eq("rst_rbuf",  RBUF_Req, 8'h00);
        check_eq("rst_drdy",  Dat_Rdy_Req, 2'b00);
        check_eq("rst_busy",  Busy_Req, 2'b11);
        check_eq("rst_rdy",   SPI_Rdy_Req, 2'b00);
        check_eq("rst_tmo",   Timeout_Flg, 1'b0);
        #2;
        RSTn = 1'b1;
        tick();

        // 1: single requester, steering of owner 0
        Req        = 2'b01;
        En_SPI_Req = 2'b11;
        CSN_Req    = 2'b00;
        #1;
        check_eq("t1_pre_gnt", Gnt, 2'b00);
        tick();
        check_eq("t1_gnt",  Gnt, 2'b01);
        check_eq("t1_en",   SPI_En, 1'b1);
        check_eq("t1_sbuf", SPI_SBUF, 8'h5A);
        check_eq("t1_csn",  CSN_Out, 2'b10);
        SPI_Dat_Rdy = 1'b1;
        SPI_RBUF    = 8'hC3;
        SPI_Busy    = 1'b1;
        #1;
        check_eq("t1_drdy", Dat_Rdy_Req, 2'b01);
        check_eq("t1_rbuf", RBUF_Req, 8'hC3);
        check_eq("t1_busy1", Busy_Req, 2'b11);
        check_eq("t1_rdy",  SPI_Rdy_Req, 2'b01);
        SPI_Busy = 1'b0;
        #1;
        check_eq("t1_busy0", Busy_Req, 2'b10);
        En_SPI_Req = 2'b10;
        #1;
        check_eq("t1_en_own0", SPI_En, 1'b0);
        SPI_Dat_Rdy = 1'b0;
        Req         = 2'b00;
        tick();
        check_eq("t1_rel_gnt", Gnt, 2'b00);
        check_eq("t1_rel_csn", CSN_Out, 2'b11);
        ticks(10);

        // 2: tie right after reset goes to req0; guard gap before req1
        pulse_reset();
        Req = 2'b11;
        tick();
        check_eq("t2_gnt0", Gnt, 2'b01);
        tick();
        Req = 2'b10;
        tick();
        check_eq("t2_rel_gnt", Gnt, 2'b00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("t2_guard_gnt", Gnt, 2'b00);
            check_eq("t2_guard_csn", CSN_Out, 2'b11);
        end
        tick();
        check_eq("t2_gnt1", Gnt, 2'b10);
        check_eq("t2_csn1", CSN_Out, 2'b01);

        // 3a: owner 1 releases and re-requests with req0 waiting -> req0 wins
        Req = 2'b01;
        tick();
        check_eq("t3a_rel", Gnt, 2'b00);
        Req = 2'b11;
        ticks(9);
        check_eq("t3a_gnt", Gnt, 2'b01);
        // 3b: owner 0 drops and re-asserts immediately while req1 held -> req1 wins
        Req = 2'b10;
        tick();
        check_eq("t3b_rel", Gnt, 2'b00);
        Req = 2'b11;
        ticks(9);
        check_eq("t3b_gnt", Gnt, 2'b10);
        Req = 2'b00;
        tick();
        ticks(10);

        // 4: timeout after 100 ownership cycles
        Req = 2'b01;
        tick();
        check_eq("t4_gnt", Gnt, 2'b01);
        ticks(99);
        check_eq("t4_hold_gnt", Gnt, 2'b01);
        check_eq("t4_hold_tmo", Timeout_Flg, 1'b0);
        tick();
        check_eq("t4_tmo", Timeout_Flg, 1'b1);
        check_eq("t4_gnt0", Gnt, 2'b00);
        check_eq("t4_csn", CSN_Out, 2'b11);
        tick();
        check_eq("t4_tmo_end", Timeout_Flg, 1'b0);
        Req = 2'b00;
        ticks(10);

        // 5: release deferred while the byte is busy
        Req = 2'b01;
        tick();
        check_eq("t5_gnt", Gnt, 2'b01);
        SPI_Busy = 1'b1;
        CSN_Req  = 2'b10;
        Req      = 2'b00;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("t5_hold_gnt", Gnt, 2'b01);
            check_eq("t5_hold_csn", CSN_Out, 2'b10);
        end
        check_eq("t5_tmo", Timeout_Flg, 1'b0);
        SPI_Busy = 1'b0;
        tick();
        check_eq("t5_rel_gnt", Gnt, 2'b00);
        check_eq("t5_rel_csn", CSN_Out, 2'b11);
        check_eq("t5_rel_tmo", Timeout_Flg, 1'b0);
        ticks(10);

        // En low blocks new grants
        En  = 1'b0;
        Req = 2'b10;
        ticks(3);
        check_eq("en0_gnt", Gnt, 2'b00);
        En = 1'b1;
        tick();
        check_eq("en1_gnt", Gnt, 2'b10);
        check_eq("en1_sbuf", SPI_SBUF, 8'h3C);

        // 6: asynchronous reset mid-byte
        CSN_Req    = 2'b00;
        SPI_Busy   = 1'b1;
        En_SPI_Req = 2'b10;
        #1;
        check_eq("t6_pre_csn", CSN_Out, 2'b01);
        check_eq("t6_pre_en", SPI_En, 1'b1);
        RSTn = 1'b0;
        #1;
        check_eq("t6_gnt",  Gnt, 2'b00);
        check_eq("t6_csn",  CSN_Out, 2'b11);
        check_eq("t6_en",   SPI_En, 1'b0);
        check_eq("t6_busy", Busy_Req, 2'b11);
        RSTn     = 1'b1;
        SPI_Busy = 1'b0;
        tick();
        check_eq("t6_regnt", Gnt, 2'b10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
